// File: rtl/adc_spi_rx.sv
// adc_spi_rx: periodic CNV/SCK/SDO capture for a serial SAR ADC, one word per SAMPLE_PERIOD clocks
module adc_spi_rx #(
    parameter int SAMPLE_PERIOD = 200,
    parameter int CNV_HIGH      = 4,
    parameter int CONV_WAIT     = 80,
    parameter int SCK_DIV       = 2,
    parameter int DATA_WIDTH    = 24
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    output logic                  o_adc_cnv,
    output logic                  o_adc_sck,
    input  logic                  i_adc_sdo,
    output logic [DATA_WIDTH-1:0] o_adc_data,
    output logic                  o_adc_valid,
    output logic                  o_overrun
);
    localparam int PW   = SAMPLE_PERIOD > 1 ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int M1   = CNV_HIGH > CONV_WAIT ? CNV_HIGH : CONV_WAIT;
    localparam int CMAX = M1 > 2 * SCK_DIV ? M1 : 2 * SCK_DIV;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int BW   = $clog2(DATA_WIDTH + 1);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CNV   = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] SHIFT = 3'd3;
    localparam logic [2:0] LATCH = 3'd4;
    localparam logic [PW-1:0] P_LAST    = PW'(SAMPLE_PERIOD - 1);
    localparam logic [CW-1:0] CNV_LAST  = CW'(CNV_HIGH - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(CONV_WAIT - 1);
    localparam logic [CW-1:0] HI_LAST   = CW'(SCK_DIV - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(2 * SCK_DIV - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);

    logic [2:0]            state, nxt_state;
    logic [PW-1:0]         p_cnt;
    logic [CW-1:0]         cnt, nxt_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] sr;
    logic                  trig, cnt_done, sample;

    always_comb begin
        trig      = i_en && p_cnt == '0;
        cnt_done  = (state == CNV && cnt == CNV_LAST) || (state == WAIT && cnt == WAIT_LAST) ||
                    (state == SHIFT && cnt == BIT_LAST);
        nxt_state = state == IDLE  ? (trig ? CNV : IDLE) :
                    state == CNV   ? (cnt_done ? WAIT : CNV) :
                    state == WAIT  ? (cnt_done ? SHIFT : WAIT) :
                    state == SHIFT ? (cnt_done && bit_cnt == LAST_BIT ? LATCH : SHIFT) : IDLE;
        nxt_cnt   = (state == IDLE || nxt_state != state || cnt_done) ? '0 : cnt + 1'b1;
        // sdo is taken on the same edge that ends the sck high phase
        sample    = state == SHIFT && cnt == HI_LAST;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state       <= IDLE;
            p_cnt       <= '0;
            cnt         <= '0;
            bit_cnt     <= '0;
            sr          <= '0;
            o_adc_cnv   <= 1'b0;
            o_adc_sck   <= 1'b0;
            o_adc_data  <= '0;
            o_adc_valid <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            p_cnt       <= (!i_en || p_cnt == P_LAST) ? '0 : p_cnt + 1'b1;
            state       <= nxt_state;
            cnt         <= nxt_cnt;
            bit_cnt     <= state != SHIFT ? '0 : cnt_done ? bit_cnt + 1'b1 : bit_cnt;
            if (sample) sr <= {sr[DATA_WIDTH-2:0], i_adc_sdo};
            o_adc_cnv   <= nxt_state == CNV;
            o_adc_sck   <= nxt_state == SHIFT && nxt_cnt <= HI_LAST;
            o_adc_valid <= nxt_state == LATCH;
            if (nxt_state == LATCH) o_adc_data <= sr;
            o_overrun   <= i_en && (o_overrun || (trig && state != IDLE));
        end
    end
endmodule

// File: tb/tb_adc_spi_rx.sv
// tb_adc_spi_rx: directed checks of adc_spi_rx timing, capture, enable handling and overrun
module tb_adc_spi_rx;
    logic clk = 1'b0, rst = 1'b0, en = 1'b0, en2 = 1'b0, sdo = 1'b0, sdo2 = 1'b0;
    logic cnv, sck, valid, ovr, cnv2, sck2, valid2, ovr2;
    logic [23:0] data, data2;
    logic [23:0] tx_word = 24'h0, tx_sh = 24'h0, ramp_cnt = 24'h0;
    bit ramp = 1'b0;
    int checks = 0, failures = 0;
    int cyc = 0, cnv_rises = 0, cnv_rise_cyc = 0, cnv_run = 0, cnv_len = 0;
    int sck_frame = 0, hi_run = 0, lo_run = 0, bad_sck = 0;
    int valid_cnt = 0, valid_lat = 0, valid_gap = 0, valid_last = 0, bad_valid = 0;
    int v2_cnt = 0, v2_gap = 0, v2_last = 0;
    logic cnv_q = 1'b0, sck_q = 1'b0, valid_q = 1'b0;

    always #5 clk = ~clk;

    adc_spi_rx dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .o_adc_cnv(cnv), .o_adc_sck(sck), .i_adc_sdo(sdo),
        .o_adc_data(data), .o_adc_valid(valid), .o_overrun(ovr)
    );
    adc_spi_rx #(.SAMPLE_PERIOD(150)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_en(en2), .o_adc_cnv(cnv2), .o_adc_sck(sck2), .i_adc_sdo(sdo2),
        .o_adc_data(data2), .o_adc_valid(valid2), .o_overrun(ovr2)
    );

    // ADC model: load the word at cnv rise, present the next bit after each sck fall
    always @(posedge cnv or negedge sck) begin
        if (cnv) begin
            if (ramp) ramp_cnt = ramp_cnt + 24'd1;
            tx_sh = ramp ? ramp_cnt : tx_word;
        end else tx_sh = tx_sh << 1;
        sdo = tx_sh[23];
    end

    always @(negedge clk) begin
        cyc++;
        if (cnv && !cnv_q) begin
            cnv_rises++;
            cnv_rise_cyc = cyc;
            cnv_run = 0;
            sck_frame = 0;
        end
        if (cnv) cnv_run++;
        else if (cnv_q) cnv_len = cnv_run;
        if (sck && !sck_q) begin
            sck_frame++;
            if (sck_frame > 1 && lo_run != 2) bad_sck++;
            hi_run = 0;
        end
        if (!sck && sck_q) begin
            if (hi_run != 2) bad_sck++;
            lo_run = 0;
        end
        if (sck) hi_run++;
        else lo_run++;
        if (valid) begin
            if (valid_q) bad_valid++;
            valid_lat = cyc - cnv_rise_cyc;
            valid_gap = cyc - valid_last;
            valid_last = cyc;
            valid_cnt++;
        end
        if (valid2) begin
            v2_gap = cyc - v2_last;
            v2_last = cyc;
            v2_cnt++;
        end
        cnv_q = cnv;
        sck_q = sck;
        valid_q = valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input string tag);
        int n0 = valid_cnt;
        bit ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            tick();
            ok = valid_cnt > n0;
        end
        check({tag, "_valid_timeout"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_cnv(input string tag);
        int n0 = cnv_rises;
        bit ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            tick();
            ok = cnv_rises > n0;
        end
        check({tag, "_cnv_timeout"}, 32'(ok), 32'd1);
    endtask

    initial begin
        int n;
        bit ok;
        tick(3);
        check("rst_ctl", 32'({cnv, sck, valid, ovr}), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        tx_word = 24'hA5C3F1;
        rst = 1'b1;
        en = 1'b1;
        tick();
        check("cnv_first", 32'(cnv), 32'd1);
        wait_valid("t2");
        check("t2_data", 32'(data), 32'hA5C3F1);
        check("t2_latency", valid_lat, 180);
        check("t2_sck_count", sck_frame, 24);
        check("t2_cnv_len", cnv_len, 4);
        tick();
        check("t2_valid_pulse", 32'(valid), 32'd0);
        check("t2_sck_shape", bad_sck, 0);
        tx_word = 24'h000000;
        wait_valid("t6a");
        check("t6_zeros", 32'(data), 32'h000000);
        check("t6_gap_a", valid_gap, 200);
        tx_word = 24'hFFFFFF;
        wait_valid("t6b");
        check("t6_ones", 32'(data), 32'hFFFFFF);
        check("t6_gap_b", valid_gap, 200);
        // async reset mid-SHIFT, between clock edges
        wait_cnv("t1");
        tick(102);
        #2 rst = 1'b0;
        #1;
        check("t1_async_ctl", 32'({cnv, sck, valid, ovr}), 32'd0);
        check("t1_async_data", 32'(data), 32'd0);
        n = valid_cnt;
        tx_word = 24'h123456;
        tick(3);
        rst = 1'b1;
        tick();
        check("t1_cnv_first", 32'(cnv), 32'd1);
        wait_valid("t1");
        check("t1_no_abort_valid", valid_cnt, n + 1);
        check("t1_data", 32'(data), 32'h123456);
        check("t1_latency", valid_lat, 180);
        ramp = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            wait_valid("t3");
            check("t3_code", 32'(data), 32'(k));
            check("t3_gap", valid_gap, 200);
            check("t3_cnv_len", cnv_len, 4);
        end
        check("t3_overrun", 32'(ovr), 32'd0);
        check("t3_sck_shape", bad_sck, 0);
        check("t3_valid_shape", bad_valid, 0);
        ramp = 1'b0;
        tx_word = 24'h5A5A5A;
        wait_cnv("t4");
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            tick();
            ok = sck_frame >= 11;
        end
        check("t4_bit10_timeout", 32'(ok), 32'd1);
        en = 1'b0;
        wait_valid("t4");
        check("t4_data", 32'(data), 32'h5A5A5A);
        check("t4_latency", valid_lat, 180);
        n = cnv_rises;
        tick(400);
        check("t4_no_cnv", cnv_rises, n);
        en = 1'b1;
        tick();
        check("t4_reenable", 32'(cnv), 32'd1);
        en2 = 1'b1;
        tick();
        check("t5_cnv", 32'(cnv2), 32'd1);
        tick(139);
        check("t5_ovr_before", 32'(ovr2), 32'd0);
        tick(16);
        check("t5_ovr_set", 32'(ovr2), 32'd1);
        n = v2_cnt;
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            tick();
            ok = v2_cnt >= n + 2;
        end
        check("t5_valid_timeout", 32'(ok), 32'd1);
        check("t5_gap", v2_gap, 300);
        en2 = 1'b0;
        tick();
        check("t5_ovr_clear", 32'(ovr2), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
